store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 36 +++
 rtl/store_buffer.sv | 86 ++++++++
 tb/tb_store_buffer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store/load side and data-memory write port.
// The buffer takes the slave modport, the MEM stage / memory side the master.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          dm_busy;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data,
        output ld_valid, ld_addr,
        output dm_busy,
        input  st_ready, ld_hit, ld_data,
        input  dm_wr, dm_addr, dm_wdata, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data,
        input  ld_valid, ld_addr,
        input  dm_busy,
        output st_ready, ld_hit, ld_data,
        output dm_wr, dm_addr, dm_wdata, empty
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between MEM stage and data memory, with store-to-load
// forwarding from the youngest matching buffered entry.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic          clk,
    input logic          rst,
    store_buffer_if.slave sb
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage carries no reset; occupancy alone decides visibility.
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic          is_empty;
    logic          is_full;
    logic          push;
    logic          pop;
    logic          hit;
    logic [DW-1:0] fwd;
    logic [PW-1:0] idx;

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == CW'(DEPTH));
        push     = sb.st_valid && !is_full;
        pop      = !is_empty && !sb.dm_busy;
        head_d   = pop  ? head_q + PW'(1) : head_q;
        tail_d   = push ? tail_q + PW'(1) : tail_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= sb.st_addr;
            data_q[tail_q] <= sb.st_data;
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == sb.ld_addr)) begin
                hit = 1'b1;
                fwd = data_q[idx];
            end
        end
    end

    assign sb.st_ready = !is_full;
    assign sb.empty    = is_empty;
    assign sb.dm_wr    = pop;
    assign sb.dm_addr  = is_empty ? '0 : addr_q[head_q];
    assign sb.dm_wdata = is_empty ? '0 : data_q[head_q];
    assign sb.ld_hit   = sb.ld_valid && hit;
    assign sb.ld_data  = (sb.ld_valid && hit) ? fwd : '0;
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit bus).
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_store_buffer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    store_buffer_if #(.AW(32), .DW(32)) sif ();

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sif.st_valid = 1'b0;
        sif.st_addr  = '0;
        sif.st_data  = '0;
        sif.ld_valid = 1'b0;
        sif.ld_addr  = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle();
        sif.dm_busy  = 1'b0;
        sif.ld_valid = 1'b1;
        #1;
        chk("rst_st_ready", sif.st_ready, 1);
        chk("rst_empty", sif.empty, 1);
        chk("rst_dm_wr", sif.dm_wr, 0);
        chk("rst_dm_addr", sif.dm_addr, 0);
        chk("rst_dm_wdata", sif.dm_wdata, 0);
        chk("rst_ld_hit", sif.ld_hit, 0);
        chk("rst_ld_data", sif.ld_data, 0);
        #1 rst = 1'b0;
        idle();

        // single store drains one cycle after push
        tick();
        sif.st_valid = 1'b1;
        sif.st_addr  = 32'h10;
        sif.st_data  = 32'hAAAA0001;
        #1;
        chk("push_cyc_dm_wr", sif.dm_wr, 0);
        tick();
        idle();
        #1;
        chk("drain_dm_wr", sif.dm_wr, 1);
        chk("drain_addr", sif.dm_addr, 32'h10);
        chk("drain_data", sif.dm_wdata, 32'hAAAA0001);
        tick();
        chk("drain_empty", sif.empty, 1);
        chk("drain_idle_wr", sif.dm_wr, 0);

        // fill while memory busy, overflow ignored, then drain in order
        sif.dm_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sif.st_valid = 1'b1;
            sif.st_addr  = k;
            sif.st_data  = 32'h100 + k;
            #1;
            chk("fill_ready", sif.st_ready, 1);
            tick();
        end
        sif.st_addr = 32'h99;
        sif.st_data = 32'h999;
        #1;
        chk("full_ready", sif.st_ready, 0);
        chk("full_busy_wr", sif.dm_wr, 0);
        tick();
        idle();
        chk("full_count", dut.count_q, 4);
        sif.dm_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fifo_wr", sif.dm_wr, 1);
            chk("fifo_addr", sif.dm_addr, k);
            chk("fifo_data", sif.dm_wdata, 32'h100 + k);
            tick();
        end
        chk("fifo_empty", sif.empty, 1);

        // forwarding picks the youngest of duplicate addresses
        sif.dm_busy  = 1'b1;
        sif.st_valid = 1'b1;
        sif.st_addr  = 32'h20;
        sif.st_data  = 32'h1;
        tick();
        sif.st_data  = 32'h2;
        tick();
        idle();
        sif.ld_valid = 1'b1;
        sif.ld_addr  = 32'h20;
        #1;
        chk("fwd_hit", sif.ld_hit, 1);
        chk("fwd_data", sif.ld_data, 32'h2);
        sif.ld_addr = 32'h24;
        #1;
        chk("miss_hit", sif.ld_hit, 0);
        chk("miss_data", sif.ld_data, 0);
        sif.ld_valid = 1'b0;
        sif.ld_addr  = 32'h20;
        #1;
        chk("noval_hit", sif.ld_hit, 0);
        sif.ld_valid = 1'b1;
        sif.dm_busy  = 1'b0;
        #1;
        chk("dup1_data", sif.dm_wdata, 32'h1);
        chk("head_fwd_data", sif.ld_data, 32'h2);
        tick();
        chk("dup2_data", sif.dm_wdata, 32'h2);
        chk("head_only_hit", sif.ld_hit, 1);
        tick();
        idle();
        chk("dup_empty", sif.empty, 1);

        // align head/tail to 0 with one filler store
        sif.st_valid = 1'b1;
        sif.st_addr  = 32'h40;
        sif.st_data  = 32'h400;
        tick();
        idle();
        tick();
        chk("align_empty", sif.empty, 1);

        // count=DEPTH-1, push and pop together, tail wraps 3 -> 0
        sif.dm_busy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            sif.st_valid = 1'b1;
            sif.st_addr  = 32'h40 + k;
            sif.st_data  = 32'h400 + k;
            tick();
        end
        chk("pre_wrap_count", dut.count_q, 3);
        chk("pre_wrap_tail", dut.tail_q, 3);
        sif.st_addr = 32'h44;
        sif.st_data = 32'h404;
        sif.dm_busy = 1'b0;
        #1;
        chk("wrap_wr_addr", sif.dm_addr, 32'h41);
        tick();
        idle();
        chk("wrap_count", dut.count_q, 3);
        chk("wrap_tail", dut.tail_q, 0);
        chk("wrap_head", dut.head_q, 1);
        for (int k = 2; k < 5; k++) begin
            chk("wrap_order", sif.dm_addr, 32'h40 + k);
            chk("wrap_wr", sif.dm_wr, 1);
            tick();
        end
        chk("wrap_empty", sif.empty, 1);

        // async reset between edges discards buffered stores
        sif.dm_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sif.st_valid = 1'b1;
            sif.st_addr  = 32'h50 + k;
            sif.st_data  = 32'h500 + k;
            tick();
        end
        idle();
        sif.dm_busy = 1'b0;
        #1;
        chk("pre_rst_wr", sif.dm_wr, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_empty", sif.empty, 1);
        chk("mid_rst_wr", sif.dm_wr, 0);
        chk("mid_rst_addr", sif.dm_addr, 0);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_wr", sif.dm_wr, 0);
        end

        // same-cycle store is not forwarded
        sif.dm_busy  = 1'b1;
        sif.st_valid = 1'b1;
        sif.st_addr  = 32'h30;
        sif.st_data  = 32'h33;
        sif.ld_valid = 1'b1;
        sif.ld_addr  = 32'h30;
        #1;
        chk("same_cyc_hit", sif.ld_hit, 0);
        tick();
        sif.st_valid = 1'b0;
        #1;
        chk("next_cyc_hit", sif.ld_hit, 1);
        chk("next_cyc_data", sif.ld_data, 32'h33);
        idle();
        sif.dm_busy = 1'b0;
        tick();
        chk("final_empty", sif.empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
